lsu_mem_ctrl: RTL and testbench
===============================

// Module: lsu_mem_ctrl
// PURPOSE
//  Parametrised LSU memory stage. Accepts one decoded load/store per cycle (valid/ready) and forms the address.
//  Aligns store data onto byte lanes, issues requests over a req/gnt memory handshake and tracks up to DEPTH
//  outstanding loads. Returns extended load data to the reg-file write port in order. Sits between the LSU
//  ID/EX register and data RAM; replaces the fixed single-cycle rd_en/wr_en path.
// PARAMETERS
//  XLEN    32  data width (32 or 64); byte lanes NB = XLEN/8
//  ADDR_W  32  memory address width
//  DEPTH   4   max outstanding loads (power of 2, >=2)
//  REG_AW  5   register index width
// PORTS
//  clk         in   1       clock, rising edge
//  rst         in   1       asynchronous, active-low reset
//  op_valid    in   1       decoded op present
//  op_ready    out  1       op accepted when op_valid && op_ready
//  op_is_load  in   1       1 = load, 0 = store
//  op_size     in   2       0 byte, 1 half, 2 word, 3 dword (XLEN=64 only)
//  op_zero_ext in   1       load zero-extends (else sign-extends)
//  op_rd       in   REG_AW  load destination
//  op_base     in   XLEN    rs1 value (already forwarded)
//  op_wdata    in   XLEN    rs2 value (store data)
//  op_imm      in   12      signed offset
//  flush       in   1       branch squash
//  mem_req     out  1       request valid
//  mem_we      out  1       1 = write
//  mem_addr    out  ADDR_W  byte address, lane bits forced 0
//  mem_be      out  NB      byte enables
//  mem_wdata   out  XLEN    lane-aligned store data
//  mem_gnt     in   1       request accepted this cycle
//  mem_rvalid  in   1       read data valid (in request order)
//  mem_rdata   in   XLEN    read data
//  wb_valid    out  1       reg-file write strobe
//  wb_rd       out  REG_AW  write register
//  wb_data     out  XLEN    extended load data
//  misalign    out  1       1-cycle pulse: accepted op misaligned/illegal size
//  busy        out  1       request pending or loads outstanding
// BEHAVIOUR
//  - Reset: mem_req, wb_valid, misalign, busy = 0; queue empty; mem_addr/be/wdata/wb_rd/wb_data = 0.
//  - ea = op_base + sext(op_imm), mod 2^XLEN; mem_addr = ea[ADDR_W-1:0] with log2(NB) LSBs cleared.
//  - Misaligned when ea is not a multiple of 2^op_size, or when op_size exceeds log2(NB).
//    Such an op is accepted and pulses misalign the next cycle; no request is issued and no writeback occurs.
//  - Request register: an accepted op loads it; mem_req rises the cycle after acceptance.
//    All mem_* outputs are held stable while mem_req && !mem_gnt.
//  - Stores: mem_be = ((1<<2^size)-1) << ea[lane bits]; mem_wdata = op_wdata << 8*ea[lane bits].
//  - Loads: mem_be is the same mask; mem_we = 0.
//  - op_ready = (!mem_req || mem_gnt) && !(op_is_load && lq_count + pending_load >= DEPTH).
//  - Load queue: a granted load pushes {rd, size, zext, lane offset, kill=0}; mem_rvalid pops the head.
//    Push and pop in the same cycle leave the count unchanged. Pointers wrap mod DEPTH.
//  - Writeback: registered, one cycle after mem_rvalid.
//    wb_data = extend((mem_rdata >> 8*offset) masked to size); wb_valid = !kill.
//  - Minimum load latency: accept N, req N+1, gnt N+1, rvalid N+2, wb_valid N+3.
//  - flush: an un-granted pending request is dropped (mem_req=0 next cycle).
//    A request granted in the flush cycle is still counted; its kill bit is set.
//    All queued entries get kill=1 and are still drained on rvalid with wb suppressed.
//    An op presented with flush is not accepted.
//  - mem_rvalid with an empty queue is a protocol error: flagged by assertion, ignored.
//  - Reset mid-operation discards all state; the memory side shares the same reset.
// STRUCTURE
//  - lsu_pkg: lsu_size_e {SZ_B,SZ_H,SZ_W,SZ_D}; lq_entry_t struct {rd,size,zext,offset,kill};
//    functions be_mask(), extend().
//  - Sub-module lsu_load_queue: DEPTH-entry circular FIFO of lq_entry_t with count, full/empty
//    and a kill_all input.
//  - The top holds the address adder, request register, ready logic and writeback register.
// TESTING
//  1 Store byte base=0x1000, imm=3, wdata=0xAB: mem_addr=0x1000, be=4'b1000, wdata=0xAB000000, we=1.
//  2 Load half, ea=0x2002, rdata=0x80010000, zext=0: wb_data=0xFFFF8001, wb_valid at N+3.
//  3 Load word, ea=0x0006: misalign=1 next cycle, mem_req stays 0, no wb_valid.
//  4 DEPTH=4, gnt every cycle, rvalid withheld: 4 loads accepted, 5th sees op_ready=0;
//    one rvalid -> ready=1 next cycle.
//  5 Two loads granted, then flush before rvalid: both rvalids consumed, wb_valid stays 0, busy->0.
//  6 gnt held low 3 cycles: mem_addr/be/wdata constant, op_ready=0; gnt=1 -> next op accepted that cycle.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the LSU memory stage.
package lsu_pkg;

  // Entry fields are sized for the widest supported configuration (64-bit, 8 lanes).
  localparam int unsigned RD_W_MAX = 8;
  localparam int unsigned OFF_W    = 3;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } lsu_size_e;

  typedef struct packed {
    logic [RD_W_MAX-1:0] rd;
    lsu_size_e           size;
    logic                zext;
    logic [OFF_W-1:0]    offset;
    logic                kill;
  } lq_entry_t;

  // Byte-enable mask: 2^size contiguous lanes starting at lane 'off'.
  function automatic logic [7:0] be_mask(lsu_size_e size, logic [OFF_W-1:0] off);
    logic [15:0] m;
    m = (16'd1 << (5'd1 << 2'(size))) - 16'd1;
    return 8'(m << off);
  endfunction

  // Sign- or zero-extend the low 2^size bytes of d.
  function automatic logic [63:0] extend(logic [63:0] d, lsu_size_e size, logic zext);
    logic [63:0] r;
    case (size)
      SZ_B:    r = {{56{~zext & d[7]}},  d[7:0]};
      SZ_H:    r = {{48{~zext & d[15]}}, d[15:0]};
      SZ_W:    r = {{32{~zext & d[31]}}, d[31:0]};
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_load_queue.sv
// Circular FIFO of outstanding loads; kill_all marks every stored entry as squashed.
module lsu_load_queue
  import lsu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  lq_entry_t     push_entry_i,
  input  logic          pop_i,
  input  logic          kill_all_i,
  output lq_entry_t     head_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  lq_entry_t     ent_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push_c;
  logic          do_pop_c;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign head_o    = ent_q[rd_ptr_q];
  assign do_push_c = push_i && !full_o;
  assign do_pop_c  = pop_i && !empty_o;

  // Storage, pointers (wrap naturally, DEPTH is a power of 2) and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (kill_all_i) begin
        for (int i = 0; i < DEPTH; i++) ent_q[i].kill <= 1'b1;
      end
      if (do_push_c) begin
        ent_q[wr_ptr_q] <= push_entry_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (do_pop_c) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(do_push_c) - CW'(do_pop_c);
    end
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// LSU memory stage: address formation, lane alignment, req/gnt issue, in-order load writeback.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned REG_AW = 5,
  localparam int unsigned NB    = XLEN / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic              op_is_load,
  input  logic [1:0]        op_size,
  input  logic              op_zero_ext,
  input  logic [REG_AW-1:0] op_rd,
  input  logic [XLEN-1:0]   op_base,
  input  logic [XLEN-1:0]   op_wdata,
  input  logic [11:0]       op_imm,
  input  logic              flush,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [NB-1:0]     mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic              misalign,
  output logic              busy
);

  localparam int unsigned LW = $clog2(NB);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0]   ea_c;
  logic [LW-1:0]     off_c;
  logic [2:0]        amask_c;
  logic              mis_c;
  logic              pending_load_c;
  logic              accept_c;
  logic              pop_c;
  logic [XLEN-1:0]   rshift_c;
  lq_entry_t         push_entry_c;
  lq_entry_t         head_c;
  logic [CW-1:0]     lq_count;
  logic              lq_full;
  logic              lq_empty;
  logic              unused_c;

  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [NB-1:0]     be_q, be_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  lsu_size_e         size_q, size_d;
  logic              zext_q, zext_d;
  logic [LW-1:0]     off_q, off_d;
  logic              mis_q, mis_d;
  logic              wb_valid_q, wb_valid_d;
  logic [REG_AW-1:0] wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d;

  // Effective address and alignment / legal-size check.
  assign ea_c    = op_base + {{(XLEN-12){op_imm[11]}}, op_imm};
  assign off_c   = ea_c[LW-1:0];
  assign amask_c = 3'((4'd1 << op_size) - 4'd1);
  assign mis_c   = (32'(op_size) > LW) || ((ea_c[2:0] & amask_c) != 3'd0);

  // Ready: request slot free and room for one more load counting the pending one.
  assign pending_load_c = req_q && !we_q;
  assign op_ready = (!req_q || mem_gnt) &&
                    !(op_is_load && ((lq_count + CW'(pending_load_c)) >= CW'(DEPTH)));
  assign accept_c = op_valid && op_ready && !flush;
  assign pop_c    = mem_rvalid && !lq_empty;
  assign rshift_c = mem_rdata >> {head_c.offset[LW-1:0], 3'b000};

  // Queue entry for the load being granted; a grant during flush is recorded as killed.
  always_comb begin
    push_entry_c        = '0;
    push_entry_c.rd     = RD_W_MAX'(rd_q);
    push_entry_c.size   = size_q;
    push_entry_c.zext   = zext_q;
    push_entry_c.offset = OFF_W'(off_q);
    push_entry_c.kill   = flush;
  end

  lsu_load_queue #(.DEPTH(DEPTH)) u_lq (
    .clk          (clk),
    .rst          (rst),
    .push_i       (pending_load_c && mem_gnt),
    .push_entry_i (push_entry_c),
    .pop_i        (pop_c),
    .kill_all_i   (flush),
    .head_o       (head_c),
    .count_o      (lq_count),
    .full_o       (lq_full),
    .empty_o      (lq_empty)
  );

  // Next state of the request and writeback registers.
  always_comb begin
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    size_d     = size_q;
    zext_d     = zext_q;
    off_d      = off_q;
    mis_d      = accept_c && mis_c;
    wb_valid_d = pop_c && !head_c.kill && !flush;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;

    if (flush) begin
      req_d = 1'b0;
    end else if (accept_c && !mis_c) begin
      req_d   = 1'b1;
      we_d    = !op_is_load;
      addr_d  = ADDR_W'(ea_c) & ~ADDR_W'(NB - 1);
      be_d    = NB'(be_mask(lsu_size_e'(op_size), OFF_W'(off_c)));
      wdata_d = op_wdata << {off_c, 3'b000};
      rd_d    = op_rd;
      size_d  = lsu_size_e'(op_size);
      zext_d  = op_zero_ext;
      off_d   = off_c;
    end else if (mem_gnt) begin
      req_d = 1'b0;
    end

    if (wb_valid_d) begin
      wb_rd_d   = REG_AW'(head_c.rd);
      wb_data_d = XLEN'(extend(64'(rshift_c), head_c.size, head_c.zext));
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      size_q     <= SZ_B;
      zext_q     <= 1'b0;
      off_q      <= '0;
      mis_q      <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      size_q     <= size_d;
      zext_q     <= zext_d;
      off_q      <= off_d;
      mis_q      <= mis_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;
  assign wb_valid  = wb_valid_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign misalign  = mis_q;
  assign busy      = req_q || !lq_empty;

  // Absorbs entry/address bits wider than this configuration needs.
  assign unused_c = ^{lq_full, head_c.rd, head_c.offset, ea_c};

  // Read data with nothing outstanding is a memory-side protocol error.
  a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (!rst) !(mem_rvalid && lq_empty))
    else $error("lsu_mem_ctrl: mem_rvalid with empty load queue");

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a queue-based reference model checked every cycle.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid, op_ready, op_is_load, op_zero_ext, flush;
  logic [1:0]  op_size;
  logic [4:0]  op_rd;
  logic [31:0] op_base, op_wdata;
  logic [11:0] op_imm;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        wb_valid, misalign, busy;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  lsu_mem_ctrl dut (
    .clk(clk), .rst(rst),
    .op_valid(op_valid), .op_ready(op_ready), .op_is_load(op_is_load), .op_size(op_size),
    .op_zero_ext(op_zero_ext), .op_rd(op_rd), .op_base(op_base), .op_wdata(op_wdata),
    .op_imm(op_imm), .flush(flush),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .misalign(misalign), .busy(busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [4:0] rd;
    int         size;
    bit         zext;
    int         off;
    bit         kill;
  } lq_t;

  lq_t         lq[$];
  bit          m_req, m_we, m_zext, m_wbv, m_mis;
  logic [31:0] m_addr, m_wdata, m_wbdata;
  logic [3:0]  m_be;
  logic [4:0]  m_rd, m_wbrd;
  int          m_size, m_off;

  function automatic bit exp_ready();
    int outstanding;
    outstanding = lq.size() + ((m_req && !m_we) ? 1 : 0);
    return (!m_req || mem_gnt) && !(op_is_load && outstanding >= 4);
  endfunction

  function automatic logic [31:0] ext_model(logic [31:0] rdata, int size, bit zext, int off);
    logic [63:0] v, mask;
    int nbits;
    nbits = 8 << size;
    mask  = (64'd1 << nbits) - 64'd1;
    v     = (64'(rdata) >> (8 * off)) & mask;
    if (!zext && ((v >> (nbits - 1)) & 64'd1) == 64'd1) v = v | ~mask;
    return v[31:0];
  endfunction

  always @(posedge clk or negedge rst) begin
    bit acc, mis;
    logic [31:0] ea;
    int nb, off;
    lq_t e, ne;
    if (!rst) begin
      lq.delete();
      m_req = 0; m_we = 0; m_zext = 0; m_wbv = 0; m_mis = 0;
      m_addr = 0; m_wdata = 0; m_wbdata = 0; m_be = 0; m_rd = 0; m_wbrd = 0;
      m_size = 0; m_off = 0;
    end else begin
      acc = op_valid && exp_ready() && !flush;
      ea  = op_base + 32'(int'($signed(op_imm)));
      nb  = 1 << op_size;
      off = int'(ea % 4);
      mis = (op_size == 2'd3) || ((ea & 32'(nb - 1)) != 0);
      m_wbv = 0;
      if (mem_rvalid && lq.size() > 0) begin
        e = lq.pop_front();
        m_wbv = !e.kill && !flush;
        if (m_wbv) begin
          m_wbrd   = e.rd;
          m_wbdata = ext_model(mem_rdata, e.size, e.zext, e.off);
        end
      end
      if (flush) foreach (lq[i]) lq[i].kill = 1;
      if (m_req && !m_we && mem_gnt) begin
        ne.rd = m_rd; ne.size = m_size; ne.zext = m_zext; ne.off = m_off; ne.kill = flush;
        lq.push_back(ne);
      end
      if (flush) m_req = 0;
      else if (acc && !mis) begin
        m_req   = 1;
        m_we    = !op_is_load;
        m_addr  = ea & 32'hFFFF_FFFC;
        m_be    = 4'(((1 << nb) - 1) << off);
        m_wdata = op_wdata << (8 * off);
        m_rd    = op_rd;
        m_size  = int'(op_size);
        m_zext  = op_zero_ext;
        m_off   = off;
      end else if (mem_gnt) m_req = 0;
      m_mis = acc && mis;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst && chk_en) begin
      chk("op_ready", 64'(op_ready), 64'(exp_ready()));
      chk("mem_req", 64'(mem_req), 64'(m_req));
      chk("busy", 64'(busy), 64'(m_req || (lq.size() != 0)));
      chk("misalign", 64'(misalign), 64'(m_mis));
      chk("wb_valid", 64'(wb_valid), 64'(m_wbv));
      if (m_req) begin
        chk("mem_we", 64'(mem_we), 64'(m_we));
        chk("mem_addr", 64'(mem_addr), 64'(m_addr));
        chk("mem_be", 64'(mem_be), 64'(m_be));
        if (m_we) chk("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
      end
      if (m_wbv) begin
        chk("wb_rd", 64'(wb_rd), 64'(m_wbrd));
        chk("wb_data", 64'(wb_data), 64'(m_wbdata));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_op();
    op_valid = 0; op_is_load = 0; op_size = 0; op_zero_ext = 0;
    op_rd = 0; op_base = 0; op_wdata = 0; op_imm = 0;
  endtask

  task automatic set_op(input bit ld, input logic [1:0] sz, input bit zx, input logic [4:0] rd,
                        input logic [31:0] base, input logic [11:0] imm, input logic [31:0] wd);
    op_valid = 1; op_is_load = ld; op_size = sz; op_zero_ext = zx;
    op_rd = rd; op_base = base; op_imm = imm; op_wdata = wd;
  endtask

  typedef struct {
    logic [1:0]  sz;
    bit          zx;
    logic [11:0] imm;
    logic [31:0] rdata;
    logic [31:0] expv;
  } ld_vec_t;

  ld_vec_t tbl[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

  initial begin
    tbl[0] = '{2'd0, 1'b1, 12'd1, 32'h0000_8000, 32'h0000_0080};
    tbl[1] = '{2'd0, 1'b0, 12'd3, 32'h7F00_0000, 32'h0000_007F};
    tbl[2] = '{2'd0, 1'b0, 12'd0, 32'h0000_00FF, 32'hFFFF_FFFF};
    tbl[3] = '{2'd1, 1'b1, 12'd2, 32'hFFFE_0000, 32'h0000_FFFE};
    tbl[4] = '{2'd1, 1'b0, 12'd0, 32'h0000_7FFF, 32'h0000_7FFF};
    tbl[5] = '{2'd2, 1'b0, 12'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    tbl[6] = '{2'd1, 1'b0, 12'd2, 32'h9ABC_1234, 32'hFFFF_9ABC};

    rst = 1; idle_op(); flush = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    #2 rst = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_misalign", 64'(misalign), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_be", 64'(mem_be), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_wb_rd", 64'(wb_rd), 64'd0);
    chk("rst_wb_data", 64'(wb_data), 64'd0);
    rst = 1; chk_en = 1;
    tick();

    // Store byte at 0x1003.
    set_op(0, 2'd0, 0, 5'd0, 32'h1000, 12'h003, 32'h0000_00AB);
    @(negedge clk); chk("t1_ready", 64'(op_ready), 64'd1);
    tick(); idle_op(); mem_gnt = 1;
    @(negedge clk);
    chk("t1_req", 64'(mem_req), 64'd1);
    chk("t1_addr", 64'(mem_addr), 64'h1000);
    chk("t1_be", 64'(mem_be), 64'b1000);
    chk("t1_wdata", 64'(mem_wdata), 64'hAB00_0000);
    chk("t1_we", 64'(mem_we), 64'd1);
    tick(); mem_gnt = 0;
    tick();

    // Sign-extended half load at 0x2002, minimum latency.
    set_op(1, 2'd1, 0, 5'd7, 32'h2000, 12'h002, 32'h0); mem_gnt = 1;
    tick(); idle_op();
    @(negedge clk);
    chk("t2_req", 64'(mem_req), 64'd1);
    chk("t2_be", 64'(mem_be), 64'b1100);
    chk("t2_we", 64'(mem_we), 64'd0);
    tick(); mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h8001_0000;
    @(negedge clk); chk("t2_wb_early", 64'(wb_valid), 64'd0);
    tick(); mem_rvalid = 0;
    @(negedge clk);
    chk("t2_wb_valid", 64'(wb_valid), 64'd1);
    chk("t2_wb_data", 64'(wb_data), 64'hFFFF_8001);
    chk("t2_wb_rd", 64'(wb_rd), 64'd7);
    tick();

    // Misaligned word and illegal dword.
    set_op(1, 2'd2, 0, 5'd3, 32'h0, 12'h006, 32'h0);
    tick(); idle_op();
    @(negedge clk);
    chk("t3_misalign", 64'(misalign), 64'd1);
    chk("t3_no_req", 64'(mem_req), 64'd0);
    tick();
    @(negedge clk);
    chk("t3_pulse_end", 64'(misalign), 64'd0);
    chk("t3_no_wb", 64'(wb_valid), 64'd0);
    set_op(1, 2'd3, 0, 5'd4, 32'h100, 12'h000, 32'h0);
    tick(); idle_op();
    @(negedge clk); chk("t3_dword_illegal", 64'(misalign), 64'd1);
    tick();

    // Load extension table.
    for (int i = 0; i < 7; i++) begin
      set_op(1, tbl[i].sz, tbl[i].zx, 5'(20 + i), 32'h800, tbl[i].imm, 32'h0); mem_gnt = 1;
      tick(); idle_op();
      tick(); mem_gnt = 0; mem_rvalid = 1; mem_rdata = tbl[i].rdata;
      tick(); mem_rvalid = 0;
      @(negedge clk); chk($sformatf("tx_wb_data%0d", i), 64'(wb_data), 64'(tbl[i].expv));
      tick();
    end

    // Queue fills at DEPTH loads.
    mem_gnt = 1;
    for (int i = 0; i < 5; i++) begin
      set_op(1, 2'd2, 0, 5'(i + 1), 32'h400 + 32'(i * 4), 12'h000, 32'h0);
      @(negedge clk); chk($sformatf("t4_ready%0d", i), 64'(op_ready), (i < 4) ? 64'd1 : 64'd0);
      tick();
    end
    mem_rvalid = 1; mem_rdata = 32'h1111_1111;
    @(negedge clk); chk("t4_full", 64'(op_ready), 64'd0);
    tick(); mem_rvalid = 0;
    @(negedge clk); chk("t4_ready_after_pop", 64'(op_ready), 64'd1);
    tick(); idle_op();
    for (int i = 0; i < 4; i++) begin
      mem_rvalid = 1; mem_rdata = 32'h2222_0000 + 32'(i);
      tick();
    end
    mem_rvalid = 0; mem_gnt = 0;
    tick();
    @(negedge clk); chk("t4_drained", 64'(busy), 64'd0);
    tick();

    // Flush with two loads outstanding; op presented during flush is dropped.
    mem_gnt = 1;
    set_op(1, 2'd2, 0, 5'd10, 32'h500, 12'h000, 32'h0);
    tick(); set_op(1, 2'd2, 0, 5'd11, 32'h504, 12'h000, 32'h0);
    tick(); idle_op();
    tick(); mem_gnt = 0; flush = 1; set_op(1, 2'd2, 0, 5'd12, 32'h508, 12'h000, 32'h0);
    tick(); idle_op(); flush = 0; mem_rvalid = 1; mem_rdata = 32'h3333_3333;
    @(negedge clk); chk("t5_flush_op_dropped", 64'(mem_req), 64'd0);
    tick();
    @(negedge clk); chk("t5_wb0", 64'(wb_valid), 64'd0);
    tick(); mem_rvalid = 0;
    @(negedge clk);
    chk("t5_wb1", 64'(wb_valid), 64'd0);
    chk("t5_idle", 64'(busy), 64'd0);
    tick();

    // Flush drops an un-granted store.
    set_op(0, 2'd2, 0, 5'd0, 32'h600, 12'h000, 32'h55);
    tick(); idle_op(); flush = 1;
    @(negedge clk); chk("t5b_req_before", 64'(mem_req), 64'd1);
    tick(); flush = 0;
    @(negedge clk); chk("t5b_req_dropped", 64'(mem_req), 64'd0);
    tick();

    // Load granted in the flush cycle is queued killed and drained silently.
    set_op(1, 2'd2, 0, 5'd13, 32'h700, 12'h000, 32'h0);
    tick(); idle_op(); mem_gnt = 1; flush = 1;
    tick(); mem_gnt = 0; flush = 0; mem_rvalid = 1; mem_rdata = 32'h4444_4444;
    @(negedge clk); chk("t5c_busy", 64'(busy), 64'd1);
    tick(); mem_rvalid = 0;
    @(negedge clk);
    chk("t5c_no_wb", 64'(wb_valid), 64'd0);
    chk("t5c_idle", 64'(busy), 64'd0);
    tick();

    // Stall: request held stable while grant is low.
    set_op(0, 2'd2, 0, 5'd0, 32'h3000, 12'h004, 32'h1234_5678);
    tick(); set_op(0, 2'd1, 0, 5'd0, 32'h3000, 12'h002, 32'h0000_BEEF);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("t6_addr%0d", k), 64'(mem_addr), 64'h3004);
      chk($sformatf("t6_be%0d", k), 64'(mem_be), 64'hF);
      chk($sformatf("t6_wdata%0d", k), 64'(mem_wdata), 64'h1234_5678);
      chk($sformatf("t6_ready%0d", k), 64'(op_ready), 64'd0);
      tick();
    end
    mem_gnt = 1;
    @(negedge clk); chk("t6_ready_on_gnt", 64'(op_ready), 64'd1);
    tick(); idle_op();
    @(negedge clk);
    chk("t6_next_addr", 64'(mem_addr), 64'h3000);
    chk("t6_next_be", 64'(mem_be), 64'b1100);
    chk("t6_next_wdata", 64'(mem_wdata), 64'hBEEF_0000);
    tick(); mem_gnt = 0;
    tick();

    // Reset in the middle of a request.
    set_op(1, 2'd2, 0, 5'd9, 32'h900, 12'h000, 32'h0);
    tick(); idle_op();
    @(negedge clk);
    rst = 0;
    #1;
    chk("t7_rst_req", 64'(mem_req), 64'd0);
    chk("t7_rst_busy", 64'(busy), 64'd0);
    chk("t7_rst_addr", 64'(mem_addr), 64'd0);
    @(negedge clk); rst = 1;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
